eth_stats_counter_rx_wide: RTL and testbench



---
 rtl/eth_stats_counter_rx_wide.sv | 147 ++++++++++++++
 tb/tb_eth_stats_counter_rx_wide.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_stats_counter_rx_wide.sv
// Passive per-frame RX statistics for a multi-byte AXI-Stream bus: byte count, error, runt,
// oversize and saturation, delivered through a one-entry valid/ready holding register.
module eth_stats_counter_rx_wide #(
  parameter int unsigned DATA_BYTES      = 1,
  parameter int unsigned COUNT_WIDTH     = 16,
  parameter int unsigned MIN_FRAME_BYTES = 64,
  parameter int unsigned MAX_FRAME_BYTES = 1518,
  parameter int unsigned DROP_WIDTH      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   axis_rx_tvalid,
  input  logic [DATA_BYTES-1:0]  axis_rx_tkeep,
  input  logic                   axis_rx_tlast,
  input  logic                   axis_rx_tuser,
  output logic                   stat_valid,
  input  logic                   stat_ready,
  output logic [COUNT_WIDTH-1:0] stat_bytes,
  output logic                   stat_good,
  output logic                   stat_runt,
  output logic                   stat_oversize,
  output logic                   stat_saturated,
  output logic [DROP_WIDTH-1:0]  drop_count
);

  localparam int unsigned KeepCntW = $clog2(DATA_BYTES + 1);
  localparam int unsigned SumW     = ((COUNT_WIDTH > KeepCntW) ? COUNT_WIDTH : KeepCntW) + 1;
  localparam logic [SumW-1:0] MaxCount = {{(SumW - COUNT_WIDTH){1'b0}}, {COUNT_WIDTH{1'b1}}};

  typedef enum logic [1:0] {StSync, StIdle, StCount, StSkip} state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] acc_q, acc_d;
  logic                   err_q, err_d;
  logic                   sat_q, sat_d;
  logic                   valid_q, valid_d;
  logic [COUNT_WIDTH-1:0] bytes_q, bytes_d;
  logic                   good_q, good_d;
  logic                   runt_q, runt_d;
  logic                   ovs_q, ovs_d;
  logic                   rsat_q, rsat_d;
  logic [DROP_WIDTH-1:0]  drop_q, drop_d;

  logic [SumW-1:0]        pop, sum;
  logic [COUNT_WIDTH-1:0] acc_nx;
  logic                   sat_nx, err_nx, in_count, beat_in_frame, done;

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(DATA_BYTES); i++) begin
      pop = pop + SumW'(axis_rx_tkeep[i]);
    end
  end

  // First beat starts from zero; continuing beats build on the running accumulator.
  always_comb begin
    in_count      = (state_q == StCount);
    sum           = (in_count ? SumW'(acc_q) : '0) + pop;
    acc_nx        = (sum > MaxCount) ? {COUNT_WIDTH{1'b1}} : sum[COUNT_WIDTH-1:0];
    sat_nx        = (in_count & sat_q) | (sum >= MaxCount);
    err_nx        = (in_count & err_q) | axis_rx_tuser;
    beat_in_frame = axis_rx_tvalid & (in_count | ((state_q == StIdle) & enable));
    done          = beat_in_frame & axis_rx_tlast;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    err_d   = err_q;
    sat_d   = sat_q;
    if (beat_in_frame) begin
      acc_d = acc_nx;
      err_d = err_nx;
      sat_d = sat_nx;
    end
    unique case (state_q)
      StSync:  if (!axis_rx_tvalid || axis_rx_tlast) state_d = StIdle;
      StIdle: begin
        if (axis_rx_tvalid && !axis_rx_tlast) state_d = enable ? StCount : StSkip;
      end
      StCount: if (axis_rx_tvalid && axis_rx_tlast) state_d = StIdle;
      StSkip:  if (axis_rx_tvalid && axis_rx_tlast) state_d = StIdle;
      default: state_d = StSync;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    bytes_d = bytes_q;
    good_d  = good_q;
    runt_d  = runt_q;
    ovs_d   = ovs_q;
    rsat_d  = rsat_q;
    drop_d  = drop_q;
    if (valid_q && stat_ready) valid_d = 1'b0;
    if (done) begin
      if (!valid_q || stat_ready) begin
        valid_d = 1'b1;
        bytes_d = acc_nx;
        good_d  = ~err_nx;
        runt_d  = (32'(acc_nx) < MIN_FRAME_BYTES);
        ovs_d   = (32'(acc_nx) > MAX_FRAME_BYTES);
        rsat_d  = sat_nx;
      end else if (drop_q != {DROP_WIDTH{1'b1}}) begin
        drop_d = drop_q + DROP_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StSync;
      acc_q   <= '0;
      err_q   <= 1'b0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      bytes_q <= '0;
      good_q  <= 1'b0;
      runt_q  <= 1'b0;
      ovs_q   <= 1'b0;
      rsat_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      bytes_q <= bytes_d;
      good_q  <= good_d;
      runt_q  <= runt_d;
      ovs_q   <= ovs_d;
      rsat_q  <= rsat_d;
      drop_q  <= drop_d;
    end
  end

  assign stat_valid     = valid_q;
  assign stat_bytes     = bytes_q;
  assign stat_good      = good_q;
  assign stat_runt      = runt_q;
  assign stat_oversize  = ovs_q;
  assign stat_saturated = rsat_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_eth_stats_counter_rx_wide.sv
// Directed bench: an 8-byte-lane instance with default widths and a 4-lane instance with an
// 8-bit byte counter (MAX_FRAME_BYTES=200) for saturation.
module tb_eth_stats_counter_rx_wide;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        tvalid_m = 1'b0;
  logic        tvalid_s = 1'b0;
  logic [7:0]  tkeep = '0;
  logic        tlast = 1'b0;
  logic        tuser = 1'b0;
  logic        stat_ready = 1'b1;

  logic        m_valid, m_good, m_runt, m_ovs, m_sat;
  logic [15:0] m_bytes;
  logic [31:0] m_drop;
  logic        s_valid, s_good, s_runt, s_ovs, s_sat;
  logic [7:0]  s_bytes;
  logic [31:0] s_drop;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  eth_stats_counter_rx_wide #(
    .DATA_BYTES(8), .COUNT_WIDTH(16), .MIN_FRAME_BYTES(64), .MAX_FRAME_BYTES(1518),
    .DROP_WIDTH(32)
  ) u_main (
    .clk(clk), .rst(rst), .enable(enable), .axis_rx_tvalid(tvalid_m),
    .axis_rx_tkeep(tkeep), .axis_rx_tlast(tlast), .axis_rx_tuser(tuser),
    .stat_valid(m_valid), .stat_ready(stat_ready), .stat_bytes(m_bytes), .stat_good(m_good),
    .stat_runt(m_runt), .stat_oversize(m_ovs), .stat_saturated(m_sat), .drop_count(m_drop)
  );

  eth_stats_counter_rx_wide #(
    .DATA_BYTES(4), .COUNT_WIDTH(8), .MIN_FRAME_BYTES(64), .MAX_FRAME_BYTES(200),
    .DROP_WIDTH(32)
  ) u_sat (
    .clk(clk), .rst(rst), .enable(enable), .axis_rx_tvalid(tvalid_s),
    .axis_rx_tkeep(tkeep[3:0]), .axis_rx_tlast(tlast), .axis_rx_tuser(tuser),
    .stat_valid(s_valid), .stat_ready(stat_ready), .stat_bytes(s_bytes), .stat_good(s_good),
    .stat_runt(s_runt), .stat_oversize(s_ovs), .stat_saturated(s_sat), .drop_count(s_drop)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input bit sel, input logic [7:0] keep, input bit last, input bit user,
                      input bit en);
    @(negedge clk);
    tvalid_m = !sel;
    tvalid_s = sel;
    tkeep    = keep;
    tlast    = last;
    tuser    = user;
    enable   = en;
  endtask

  task automatic idle();
    @(negedge clk);
    tvalid_m = 1'b0;
    tvalid_s = 1'b0;
    tlast    = 1'b0;
    tuser    = 1'b0;
  endtask

  task automatic send_frame(input bit sel, input int nbytes, input int user_beat, input bit en0,
                            input bit en_rest);
    int bpb = sel ? 4 : 8;
    int rem = nbytes;
    int idx = 0;
    while (rem > 0) begin
      int n = (rem > bpb) ? bpb : rem;
      logic [7:0] keep = 8'((1 << n) - 1);
      beat(sel, keep, rem <= bpb, idx == user_beat, (idx == 0) ? en0 : en_rest);
      rem -= n;
      idx++;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_bytes", 32'(m_bytes), 0);
    check("rst_good", 32'(m_good), 0);
    check("rst_drop", m_drop, 0);
    rst = 1'b0;
    idle();
    idle();

    // 60-byte frame: seven full beats plus tkeep=0F
    send_frame(0, 60, -1, 1, 1);
    idle();
    check("f60_valid", 32'(m_valid), 1);
    check("f60_bytes", 32'(m_bytes), 60);
    check("f60_runt", 32'(m_runt), 1);
    check("f60_good", 32'(m_good), 1);
    check("f60_ovs", 32'(m_ovs), 0);
    check("f60_sat", 32'(m_sat), 0);
    idle();
    check("f60_valid_one_cycle", 32'(m_valid), 0);

    // Empty-keep beat carrying tuser, then a non-contiguous mask
    beat(0, 8'hFF, 0, 0, 1);
    beat(0, 8'h00, 0, 1, 1);
    beat(0, 8'hA5, 1, 0, 1);
    idle();
    check("sparse_bytes", 32'(m_bytes), 12);
    check("sparse_good", 32'(m_good), 0);

    send_frame(0, 1519, 189, 1, 1);
    idle();
    check("f1519_bytes", 32'(m_bytes), 1519);
    check("f1519_ovs", 32'(m_ovs), 1);
    check("f1519_good", 32'(m_good), 0);
    check("f1519_runt", 32'(m_runt), 0);
    send_frame(0, 1518, -1, 1, 1);
    idle();
    check("f1518_bytes", 32'(m_bytes), 1518);
    check("f1518_ovs", 32'(m_ovs), 0);
    check("f1518_good", 32'(m_good), 1);

    // 100 beats x 4 bytes on the 8-bit counter clamps at 255
    send_frame(1, 400, -1, 1, 1);
    idle();
    check("sat_valid", 32'(s_valid), 1);
    check("sat_bytes", 32'(s_bytes), 255);
    check("sat_flag", 32'(s_sat), 1);
    check("sat_ovs", 32'(s_ovs), 1);
    send_frame(1, 64, -1, 1, 1);
    idle();
    check("sat_next_bytes", 32'(s_bytes), 64);
    check("sat_next_flag", 32'(s_sat), 0);
    check("sat_next_ovs", 32'(s_ovs), 0);
    check("sat_next_runt", 32'(s_runt), 0);
    check("sat_drop", s_drop, 0);
    idle();

    // Back-pressure: first (errored) record held, two dropped
    stat_ready = 1'b0;
    send_frame(0, 64, 0, 1, 1);
    send_frame(0, 64, -1, 1, 1);
    send_frame(0, 64, -1, 1, 1);
    idle();
    check("bp_valid", 32'(m_valid), 1);
    check("bp_bytes", 32'(m_bytes), 64);
    check("bp_held_good", 32'(m_good), 0);
    check("bp_drop", m_drop, 2);
    for (int i = 0; i < 8; i++) beat(0, 8'hFF, 0, 0, 1);
    beat(0, 8'hFF, 1, 0, 1);
    stat_ready = 1'b1;
    idle();
    check("bp4_valid", 32'(m_valid), 1);
    check("bp4_bytes", 32'(m_bytes), 72);
    check("bp4_good", 32'(m_good), 1);
    check("bp4_drop", m_drop, 2);
    idle();
    check("bp4_consumed", 32'(m_valid), 0);

    // enable low at the first beat: no record even though raised mid-frame
    send_frame(0, 64, -1, 0, 1);
    idle();
    idle();
    check("skip_no_record", 32'(m_valid), 0);
    send_frame(0, 80, -1, 1, 1);
    idle();
    check("after_skip_valid", 32'(m_valid), 1);
    check("after_skip_bytes", 32'(m_bytes), 80);
    idle();

    // Reset during beat 3 of a 10-beat frame
    for (int i = 0; i < 3; i++) beat(0, 8'hFF, 0, 0, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_drop", m_drop, 0);
    check("midrst_good", 32'(m_good), 0);
    rst = 1'b0;
    for (int i = 3; i < 10; i++) beat(0, 8'hFF, i == 9, 0, 1);
    idle();
    check("midrst_tail_no_record", 32'(m_valid), 0);
    idle();
    send_frame(0, 100, -1, 1, 1);
    idle();
    check("midrst_next_valid", 32'(m_valid), 1);
    check("midrst_next_bytes", 32'(m_bytes), 100);
    check("midrst_next_runt", 32'(m_runt), 0);
    check("midrst_next_good", 32'(m_good), 1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
